pwm_duty_meter: RTL and testbench

- Receive-side counterpart of the team's PWM generator: measures the duty cycle of an incoming PWM waveform in tenths (0..PERIOD clocks high per PERIOD-clock frame).
- Sits on the input side of a design, e.g. reading back a generator output or an external PWM source.
- Reports a validated 4-bit duty value, a new-result strobe, a lock flag and a period-error strobe.

---
 rtl/pwm_duty_meter.sv | 231 +++++++++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// -----------------------------------------------------------------------------
// pwm_duty_meter
//
// Measures the duty cycle of an incoming PWM waveform. The result is the
// number of clk cycles the input was high within a PERIOD-clock frame.
// Periods are delimited by rising edges of the synchronized input. A period
// of the wrong length is flagged instead of reported. A static input is
// reported as 0 or PERIOD once TIMEOUT cycles pass with no rising edge.
//
// Parameters:
//   PERIOD      expected PWM period in clk cycles (duty range 0..PERIOD)
//   TIMEOUT     cycles without a rising edge before the input counts as
//               static; must be > PERIOD and <= 31
//   SYNC_STAGES synchronizer depth on pwm_in, at least 2
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   pwm_in     PWM input, asynchronous to clk
//   duty_out   last accepted duty (clk cycles high per period)
//   duty_valid one-cycle pulse when duty_out has been (re)written
//   locked     high while the input matches PERIOD or is static
//   period_err one-cycle pulse when a period closes with the wrong length
//
// Build option:
//   PWM_METER_CONFIRM_EN  when defined, a good period updates duty_out only
//                         if its high count repeats that of the preceding
//                         good period; timeout results still apply at once.
// -----------------------------------------------------------------------------
module pwm_duty_meter #(
  parameter int PERIOD      = 10,
  parameter int TIMEOUT     = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [3:0] duty_out,
  output logic       duty_valid,
  output logic       locked,
  output logic       period_err
);

  localparam logic [4:0] PERIOD_CNT  = 5'(PERIOD);
  localparam logic [3:0] PERIOD_DUTY = 4'(PERIOD);
  localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_d_q;
  logic                   pwm_s;
  logic                   rise_s;
  logic                   fall_s;
  logic                   timeout_s;
  logic                   close_s;
  logic                   good_s;

  logic [4:0] per_cnt_q;
  logic [4:0] per_cnt_d;
  logic [4:0] high_cnt_q;
  logic [4:0] high_cnt_d;

  state_e     state_q;

  logic [3:0] duty_q;
  logic [3:0] duty_d;
  logic       valid_q;
  logic       valid_d;
  logic       locked_q;
  logic       locked_d;
  logic       err_q;
  logic       err_d;

`ifdef PWM_METER_CONFIRM_EN
  logic [4:0] cand_q;
  logic [4:0] cand_d;
  logic       cand_vld_q;
  logic       cand_vld_d;
`endif

  // Edge detection on the synchronized input, plus the period-close and
  // static-input conditions that drive everything else.
  always_comb begin
    pwm_s     = sync_q[SYNC_STAGES-1];
    rise_s    = pwm_s & ~pwm_d_q;
    fall_s    = ~pwm_s & pwm_d_q;
    // A rise always wins over a timeout, so the timeout is masked by it.
    timeout_s = (per_cnt_q == TIMEOUT_CNT) && !rise_s;
    // Only a rise seen in LOW closes a period: the first rise after reset
    // or a timeout just opens one.
    close_s   = rise_s && (state_q == LOW);
    good_s    = close_s && (per_cnt_q == PERIOD_CNT);
  end

  // Period and high-time counters; a rise restarts both, already counting
  // the rise cycle itself, so the closing rise sees the full frame.
  always_comb begin
    per_cnt_d  = per_cnt_q;
    high_cnt_d = high_cnt_q;
    if (rise_s) begin
      per_cnt_d  = 5'd1;
      high_cnt_d = 5'd1;
    end else if (timeout_s) begin
      per_cnt_d  = 5'd0;
      high_cnt_d = high_cnt_q + {4'd0, pwm_s};
    end else begin
      per_cnt_d  = per_cnt_q + 5'd1;
      high_cnt_d = high_cnt_q + {4'd0, pwm_s};
    end
  end

  // Result evaluation: timeout reports the static level, a closing period
  // reports its high count or flags a wrong length.
  always_comb begin
    duty_d   = duty_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;
`ifdef PWM_METER_CONFIRM_EN
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
`endif
    if (timeout_s) begin
      duty_d   = pwm_s ? PERIOD_DUTY : 4'd0;
      valid_d  = 1'b1;
      locked_d = 1'b1;
`ifdef PWM_METER_CONFIRM_EN
      cand_vld_d = 1'b0;
`endif
    end else if (close_s) begin
      if (good_s) begin
        locked_d = 1'b1;
`ifdef PWM_METER_CONFIRM_EN
        // Two consecutive good periods must agree before the value is
        // published; the newest one always becomes the candidate.
        if (cand_vld_q && (high_cnt_q == cand_q)) begin
          duty_d  = 4'(high_cnt_q);
          valid_d = 1'b1;
        end else begin
          duty_d  = duty_q;
          valid_d = 1'b0;
        end
        cand_d     = high_cnt_q;
        cand_vld_d = 1'b1;
`else
        duty_d  = 4'(high_cnt_q);
        valid_d = 1'b1;
`endif
      end else begin
        err_d    = 1'b1;
        locked_d = 1'b0;
`ifdef PWM_METER_CONFIRM_EN
        cand_vld_d = 1'b0;
`endif
      end
    end else begin
      duty_d = duty_q;
    end
  end

  // Input synchronizer and one-cycle delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      pwm_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d_q <= pwm_s;
    end
  end

  // Counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt_q  <= 5'd0;
      high_cnt_q <= 5'd0;
      duty_q     <= 4'd0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      per_cnt_q  <= per_cnt_d;
      high_cnt_q <= high_cnt_d;
      duty_q     <= duty_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

`ifdef PWM_METER_CONFIRM_EN
  // Candidate duty awaiting confirmation by the next good period.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q     <= 5'd0;
      cand_vld_q <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
    end
  end
`endif

  // Period-tracking FSM; a timeout sends it back to SEARCH from any state,
  // even when a fall arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
    end else if (timeout_s) begin
      state_q <= SEARCH;
    end else begin
      case (state_q)
        SEARCH:  if (rise_s) state_q <= HIGH;
        HIGH:    if (fall_s) state_q <= LOW;
        LOW:     if (rise_s) state_q <= HIGH;
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign duty_out   = duty_q;
  assign duty_valid = valid_q;
  assign locked     = locked_q;
  assign period_err = err_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_meter
//
// Drives pwm_duty_meter with directed PWM streams followed by random
// segments. A reference model works on the recorded history of input levels:
// it finds the rising edges of the synchronized level, and from their
// spacing and the number of high cycles between them it derives each
// expected result. Every expected result is queued with its clock index. A
// separate monitor pops and compares whenever the DUT presents duty_valid or
// period_err. It also checks duty_out and locked on every cycle.
// -----------------------------------------------------------------------------
module tb_pwm_duty_meter;

  localparam int PERIOD  = 10;
  localparam int TIMEOUT = 20;
  localparam int SYNC    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic [3:0] duty_out;
  logic       duty_valid;
  logic       locked;
  logic       period_err;

  pwm_duty_meter #(
    .PERIOD     (PERIOD),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .duty_out  (duty_out),
    .duty_valid(duty_valid),
    .locked    (locked),
    .period_err(period_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit       is_err;
    bit [3:0] duty;
    bit       lock;
  } ev_t;

  ev_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  // Reference model state: input history plus the few facts needed to judge
  // each rising edge.
  bit       pin_h[$];
  bit       rst_h[$];
  bit       lvl_h[$];
  int       k_now     = 0;
  bit       armed     = 1'b0;
  int       last_rise = 0;
  int       anchor    = 0;
  bit [3:0] exp_duty  = 4'd0;
  bit       exp_lock  = 1'b0;
  bit       cand_ok   = 1'b0;
  int       cand      = 0;

  function automatic void push_ev(int k, bit is_err, bit [3:0] d, bit l);
    ev_t e;
    e.cyc    = k;
    e.is_err = is_err;
    e.duty   = d;
    e.lock   = l;
    sb.push_back(e);
  endfunction

  // Evaluate the model for clock edge k, whose inputs are already recorded.
  function automatic void model_step(int k);
    bit lvl;
    bit prev;
    int high;
    // The meter sees pwm_in SYNC edges late, and a reset within that window
    // clears the pipeline.
    lvl = (k >= SYNC) ? pin_h[k-SYNC] : 1'b0;
    for (int i = 1; i <= SYNC; i++) begin
      if (k - i >= 0 && rst_h[k-i]) lvl = 1'b0;
    end
    lvl_h.push_back(lvl);
    prev = (k >= 1 && !rst_h[k-1]) ? lvl_h[k-1] : 1'b0;

    if (rst_h[k]) begin
      exp_duty = 4'd0;
      exp_lock = 1'b0;
      armed    = 1'b0;
      cand_ok  = 1'b0;
      anchor   = k + 1;
    end else if (lvl && !prev) begin
      if (armed) begin
        high = 0;
        for (int i = last_rise; i < k; i++) high += int'(lvl_h[i]);
        if (k - last_rise == PERIOD) begin
          exp_lock = 1'b1;
`ifdef PWM_METER_CONFIRM_EN
          if (cand_ok && cand == high) begin
            exp_duty = 4'(high);
            push_ev(k, 1'b0, exp_duty, exp_lock);
          end
          cand    = high;
          cand_ok = 1'b1;
`else
          exp_duty = 4'(high);
          push_ev(k, 1'b0, exp_duty, exp_lock);
`endif
        end else begin
          exp_lock = 1'b0;
          cand_ok  = 1'b0;
          push_ev(k, 1'b1, exp_duty, exp_lock);
        end
      end
      armed     = 1'b1;
      last_rise = k;
      anchor    = k;
    end else if (k - anchor == TIMEOUT - 1) begin
      exp_duty = lvl ? 4'(PERIOD) : 4'd0;
      exp_lock = 1'b1;
      cand_ok  = 1'b0;
      armed    = 1'b0;
      anchor   = k + 1;
      push_ev(k, 1'b0, exp_duty, exp_lock);
    end
  endfunction

  // Apply inputs for the next rising edge, update the model, wait a cycle.
  task automatic step(input bit lvl, input bit rst);
    pwm_in = lvl;
    reset  = rst;
    pin_h.push_back(lvl);
    rst_h.push_back(rst);
    model_step(k_now);
    k_now++;
    @(negedge clk);
  endtask

  task automatic pwm(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) step(1'b1, 1'b0);
      for (int i = 0; i < l; i++) step(1'b0, 1'b0);
    end
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) step(v, 1'b0);
  endtask

  // Monitor: compares DUT results against the scoreboard queue.
  initial begin
    int  mk;
    bit  want;
    ev_t e;
    mk = 0;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc < mk) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL stale_event cyc=%0d expected edge=%0d", mk, e.cyc);
      end
      want = (sb.size() > 0) && (sb[0].cyc == mk);
      checks++;
      if (want != (duty_valid || period_err)) begin
        failures++;
        $display("FAIL event_presence cyc=%0d got valid=%0b err=%0b want_event=%0b",
                 mk, duty_valid, period_err, want);
        if (want) e = sb.pop_front();
      end else if (want) begin
        e = sb.pop_front();
        if (duty_valid !== !e.is_err || period_err !== e.is_err ||
            duty_out !== e.duty || locked !== e.lock) begin
          failures++;
          $display("FAIL event_value cyc=%0d got valid=%0b err=%0b duty=%0d locked=%0b want valid=%0b err=%0b duty=%0d locked=%0b",
                   mk, duty_valid, period_err, duty_out, locked,
                   !e.is_err, e.is_err, e.duty, e.lock);
        end
      end
      checks++;
      if (duty_out !== exp_duty || locked !== exp_lock) begin
        failures++;
        $display("FAIL steady_state cyc=%0d got duty=%0d locked=%0b want duty=%0d locked=%0b",
                 mk, duty_out, locked, exp_duty, exp_lock);
      end
      mk++;
    end
  end

  // Stimulus: directed scenarios first, then random segments.
  initial begin
    int sel;
    int h;
    reset  = 1'b1;
    pwm_in = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

    pwm(5, 5, 6);              // basic 50 % stream
    pwm(1, 9, 5);              // duty 1
    pwm(9, 1, 5);              // duty 9
    hold(1'b1, 45);            // static high -> repeated PERIOD reports
    hold(1'b0, 45);            // static low -> repeated 0 reports
    pwm(5, 5, 4);
    pwm(6, 6, 3);              // wrong period -> period_err, duty held
    pwm(3, 7, 4);              // back to legal period
    pwm(5, 5, 3);
    pwm(7, 3, 4);              // duty change at a period boundary
    pwm(5, 5, 2);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);          // reset in the middle of a high phase
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    hold(1'b0, 5);
    pwm(5, 5, 4);

    for (int s = 0; s < 60; s++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) begin
        h = int'($urandom_range(1, PERIOD - 1));
        pwm(h, PERIOD - h, int'($urandom_range(1, 4)));
      end else if (sel < 8) begin
        pwm(int'($urandom_range(1, 13)), int'($urandom_range(1, 13)),
            int'($urandom_range(1, 3)));
      end else if (sel == 8) begin
        hold(1'($urandom_range(0, 1)), int'($urandom_range(5, 50)));
      end else begin
        step(1'($urandom_range(0, 1)), 1'b1);
      end
    end

    hold(1'b0, 30);
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL leftover_events got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
